// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches 16-bit words from a synchronous
// instruction ROM, decodes them and drives data-memory, register-file and
// ALU control strobes for NOOP / STORE / LOAD / ADD / SUB / HALT.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   Init    | post-reset idle cycle, PC already at 0 so ROM[0] is on Instr_In
//   Fetch   | capture Instr_In into IR, advance PC
//   Decode  | select execute state from IR opcode (unknown opcodes -> NoOp)
//   NoOp    | no strobes, back to Fetch
//   Load_A  | present memory address, wait out the memory read latency
//   Load_B  | write memory data into the register file
//   Store   | one-cycle data-memory write of register Ra
//   Add     | Rw <= Ra + Rb
//   Sub     | Rw <= Ra - Rb
//   Halt    | terminal; PC and IR frozen until reset
module control_unit #(
  parameter int PC_W = 7,
  parameter int DA_W = 8
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic [15:0]     Instr_In,
  output logic [PC_W-1:0] PC_Out,
  output logic [15:0]     IR_Out,
  output logic [3:0]      State,
  output logic [3:0]      NextState,
  output logic [DA_W-1:0] D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic            RF_W_en,
  output logic [3:0]      RF_W_Addr,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic [2:0]      ALU_Sel
);

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      opcode;

  assign opcode = ir_q[15:12];

  // Next-state, PC and IR update; PC and IR only move in Fetch so the ROM
  // address is stable for the whole instruction.
  always_comb begin
    state_d = ST_INIT;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH: begin
        state_d = ST_DECODE;
        ir_d    = Instr_In;
        pc_d    = pc_q + PC_W'(1);
      end
      ST_DECODE: begin
        case (opcode)
          OP_NOOP:  state_d = ST_NOOP;
          OP_STORE: state_d = ST_STORE;
          OP_LOAD:  state_d = ST_LOAD_A;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
          default:  state_d = ST_NOOP;
        endcase
      end
      ST_NOOP, ST_STORE, ST_LOAD_B, ST_ADD, ST_SUB: state_d = ST_FETCH;
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_INIT;
    endcase
  end

  // State, PC and IR registers with asynchronous clear.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Moore decode of strobes and addresses from the current state and IR.
  always_comb begin
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_Addr  = 4'd0;
    RF_Ra_Addr = 4'd0;
    RF_Rb_Addr = 4'd0;
    ALU_Sel    = 3'b000;
    case (state_q)
      ST_LOAD_A: begin
        D_Addr    = DA_W'(ir_q[11:4]);
        RF_W_Addr = ir_q[3:0];
        RF_s      = 1'b1;
      end
      ST_LOAD_B: begin
        D_Addr    = DA_W'(ir_q[11:4]);
        RF_W_Addr = ir_q[3:0];
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
      end
      ST_STORE: begin
        D_Addr     = DA_W'(ir_q[7:0]);
        RF_Ra_Addr = ir_q[11:8];
        D_Wr       = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        RF_Ra_Addr = ir_q[11:8];
        RF_Rb_Addr = ir_q[7:4];
        RF_W_Addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
        ALU_Sel    = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign State     = state_q;
  assign NextState = state_d;
  assign PC_Out    = pc_q;
  assign IR_Out    = ir_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a synchronous ROM model feeds a directed program
// followed by random instructions up to the PC wrap, then a HALT; an
// instruction-level reference model lists the expected per-cycle outputs.
// Finishes with asynchronous-reset aborts of LOAD and STORE.
module tb_control_unit;
  localparam int PC_W = 7;
  localparam int DA_W = 8;

  logic            Clk = 1'b0;
  logic            ResetN = 1'b0;
  logic [15:0]     Instr_In = 16'h0000;
  logic [PC_W-1:0] PC_Out;
  logic [15:0]     IR_Out;
  logic [3:0]      State, NextState;
  logic [DA_W-1:0] D_Addr;
  logic            D_Wr, RF_s, RF_W_en;
  logic [3:0]      RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr;
  logic [2:0]      ALU_Sel;

  control_unit #(.PC_W(PC_W), .DA_W(DA_W)) dut (
    .Clk(Clk), .ResetN(ResetN), .Instr_In(Instr_In),
    .PC_Out(PC_Out), .IR_Out(IR_Out), .State(State), .NextState(NextState),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
    .RF_W_Addr(RF_W_Addr), .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
    .ALU_Sel(ALU_Sel)
  );

  // Clock generation.
  always #5 Clk = ~Clk;

  // Synchronous instruction ROM.
  logic [15:0] rom [0:127];
  always @(posedge Clk) Instr_In <= rom[PC_Out];

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  nst;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [7:0]  da;
    logic        dwr;
    logic        rfs;
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          m_pc;
  logic [15:0] m_ir;
  exp_t        exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
    end
  endtask

  task automatic chk_cycle(input exp_t e, input string where);
    chk({where, " State"},      16'(State),      16'(e.st));
    chk({where, " NextState"},  16'(NextState),  16'(e.nst));
    chk({where, " PC_Out"},     16'(PC_Out),     16'(e.pc));
    chk({where, " IR_Out"},     IR_Out,          e.ir);
    chk({where, " D_Addr"},     16'(D_Addr),     16'(e.da));
    chk({where, " D_Wr"},       16'(D_Wr),       16'(e.dwr));
    chk({where, " RF_s"},       16'(RF_s),       16'(e.rfs));
    chk({where, " RF_W_en"},    16'(RF_W_en),    16'(e.we));
    chk({where, " RF_W_Addr"},  16'(RF_W_Addr),  16'(e.wa));
    chk({where, " RF_Ra_Addr"}, 16'(RF_Ra_Addr), 16'(e.ra));
    chk({where, " RF_Rb_Addr"}, 16'(RF_Rb_Addr), 16'(e.rb));
    chk({where, " ALU_Sel"},    16'(ALU_Sel),    16'(e.alu));
  endtask

  // A cycle with no strobes, PC and IR taken from the model.
  function automatic exp_t idle(input logic [3:0] st, input logic [3:0] nst);
    exp_t e;
    e.st = st;  e.nst = nst;
    e.pc = 7'(m_pc);  e.ir = m_ir;
    e.da = 8'h00; e.dwr = 1'b0; e.rfs = 1'b0; e.we = 1'b0;
    e.wa = 4'd0; e.ra = 4'd0; e.rb = 4'd0; e.alu = 3'd0;
    return e;
  endfunction

  // Instruction-level model: expected cycles from Fetch entry to the next
  // Fetch entry (HALT: Fetch, Decode, then halt_cycles of Halt).
  task automatic run_instr(input logic [15:0] w, input int halt_cycles);
    exp_t       e;
    logic [3:0] xst;
    int         at_pc;
    at_pc = m_pc;
    case (w[15:12])
      4'h0:    xst = 4'd3;
      4'h1:    xst = 4'd6;
      4'h2:    xst = 4'd4;
      4'h3:    xst = 4'd7;
      4'h4:    xst = 4'd8;
      4'h5:    xst = 4'd9;
      default: xst = 4'd3;
    endcase
    exp_q.delete();
    exp_q.push_back(idle(4'd1, 4'd2));
    m_ir = w;
    m_pc = (m_pc + 1) % 128;
    exp_q.push_back(idle(4'd2, xst));
    case (xst)
      4'd4: begin
        e = idle(4'd4, 4'd5);
        e.da = w[11:4]; e.wa = w[3:0]; e.rfs = 1'b1;
        exp_q.push_back(e);
        e.st = 4'd5; e.nst = 4'd1; e.we = 1'b1;
        exp_q.push_back(e);
      end
      4'd6: begin
        e = idle(4'd6, 4'd1);
        e.da = w[7:0]; e.ra = w[11:8]; e.dwr = 1'b1;
        exp_q.push_back(e);
      end
      4'd7, 4'd8: begin
        e = idle(xst, 4'd1);
        e.ra = w[11:8]; e.rb = w[7:4]; e.wa = w[3:0]; e.we = 1'b1;
        e.alu = (xst == 4'd7) ? 3'd1 : 3'd2;
        exp_q.push_back(e);
      end
      4'd9: for (int k = 0; k < halt_cycles; k++) exp_q.push_back(idle(4'd9, 4'd9));
      default: exp_q.push_back(idle(4'd3, 4'd1));
    endcase
    foreach (exp_q[i]) begin
      @(negedge Clk);
      chk_cycle(exp_q[i], $sformatf("pc%0d_w%h_cyc%0d", at_pc, w, i));
    end
  endtask

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rom[0] = 16'h2A03;
    rom[1] = 16'h3124;
    rom[2] = 16'h4124;
    rom[3] = 16'h1580;
    rom[4] = 16'h9ABC;
    for (int i = 5; i < 127; i++) begin
      op = int'($urandom_range(0, 14));
      if (op >= 5) op = op + 1;
      rom[i] = {op[3:0], 12'($urandom)};
    end
    rom[127] = 16'h0000;

    // Reset state, including NextState reading Fetch while held in reset.
    ResetN = 1'b0;
    repeat (3) @(negedge Clk);
    m_pc = 0;
    m_ir = 16'h0000;
    chk_cycle(idle(4'd0, 4'd1), "reset");
    ResetN = 1'b1;
    #1;
    chk_cycle(idle(4'd0, 4'd1), "released");

    // Full pass through the ROM, wrapping to 0 where HALT is now stored.
    for (int i = 0; i < 128; i++) begin
      run_instr(rom[i], 0);
      if (i == 0) rom[0] = 16'h5000;
    end
    chk("wrap_pc_zero_before_halt", 16'(m_pc), 16'd0);
    run_instr(16'h5000, 12);

    // Reset leaves Halt asynchronously.
    ResetN = 1'b0;
    #1;
    m_pc = 0;
    m_ir = 16'h0000;
    chk_cycle(idle(4'd0, 4'd1), "halt_reset");

    // Reset mid Load_A: immediate clear, no RF_W_en afterwards.
    rom[0] = 16'h2A03;
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    repeat (3) @(posedge Clk);
    #2;
    chk("pre_abort_load State", 16'(State), 16'd4);
    ResetN = 1'b0;
    #1;
    chk_cycle(idle(4'd0, 4'd1), "abort_load");
    repeat (4) begin
      @(posedge Clk);
      #1 chk("abort_load RF_W_en", 16'(RF_W_en), 16'd0);
      chk("abort_load State", 16'(State), 16'd0);
    end

    // Reset mid Store: D_Wr drops at once and stays low.
    rom[0] = 16'h1580;
    @(negedge Clk);
    ResetN = 1'b1;
    repeat (3) @(posedge Clk);
    #2;
    chk("pre_abort_store State", 16'(State), 16'd6);
    chk("pre_abort_store D_Wr", 16'(D_Wr), 16'd1);
    ResetN = 1'b0;
    #1;
    chk_cycle(idle(4'd0, 4'd1), "abort_store");
    repeat (4) begin
      @(posedge Clk);
      #1 chk("abort_store D_Wr", 16'(D_Wr), 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have parameter PC_W, default 7, the program counter width (instruction ROM depth 2^PC_W).
REQ-002 The module SHALL have parameter DA_W, default 8, the data memory address width.
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset, with the ports below (clock and reset first).
REQ-004 Port Clk, input, 1 bit: system clock; all state changes occur on its rising edge.
REQ-005 Port ResetN, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port Instr_In, input, 16 bits: synchronous instruction ROM read data for address PC_Out; valid one cycle after PC_Out changes.
REQ-007 Port PC_Out, output, PC_W bits: program counter, which drives the ROM address.
REQ-008 Port IR_Out, output, 16 bits: instruction register.
REQ-009 Port State, output, 4 bits: current FSM state.
REQ-010 Port NextState, output, 4 bits: combinational next state.
REQ-011 Port D_Addr, output, DA_W bits: data memory address.
REQ-012 Port D_Wr, output, 1 bit: data memory write strobe.
REQ-013 Port RF_s, output, 1 bit: register-file write-data select (1 = memory, 0 = ALU).
REQ-014 Port RF_W_en, output, 1 bit: register-file write enable.
REQ-015 Ports RF_W_Addr, RF_Ra_Addr and RF_Rb_Addr, outputs, 4 bits each: register-file write address, read port A address and read port B address.
REQ-016 Port ALU_Sel, output, 3 bits: ALU operation (000 = zero, 001 = A+B, 010 = A-B).

Function
REQ-017 The state encoding SHALL be: Init=0, Fetch=1, Decode=2, NoOp=3, Load_A=4, Load_B=5, Store=6, Add=7, Sub=8, Halt=9.
REQ-018 The opcode SHALL be IR_Out[15:12], with 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB and 0101 HALT.
REQ-019 State transitions SHALL be: Init->Fetch; Fetch->Decode; Decode->Store, Load_A, Add, Sub, Halt or NoOp by opcode; NoOp, Store, Load_B, Add and Sub->Fetch; Load_A->Load_B; Halt->Halt.
REQ-020 Decode SHALL route opcodes 0110-1111 to NoOp, so an illegal opcode is never a hang.
REQ-021 In Fetch, the module SHALL capture IR_Out<=Instr_In and set PC_Out<=PC_Out+1 on the same edge.
REQ-022 The PC SHALL wrap from 2^PC_W-1 to 0 without a flag.
REQ-023 IR_Out and PC_Out SHALL change only in Fetch, so the PC is stable for at least 2 cycles before the next Fetch and the synchronous ROM meets timing.
REQ-024 Strobe outputs SHALL be Moore-decoded from State and IR_Out; in any state not listed in REQ-025 to REQ-028, all strobes and ALU_Sel are 0.
REQ-025 In LOAD (Load_A and Load_B), D_Addr=IR[11:4] and RF_W_Addr=IR[3:0]; RF_s=1 in both states; RF_W_en=1 in Load_B only, allowing one cycle of memory read latency.
REQ-026 In Store, D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8] and D_Wr=1 for exactly one cycle.
REQ-027 In Add and Sub, RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_s=0 and RF_W_en=1 for one cycle; ALU_Sel is 001 in Add and 010 in Sub.
REQ-028 Address outputs SHALL hold their IR-derived values in their own states and be 0 elsewhere.
REQ-029 Halt SHALL be terminal: the PC and IR freeze, all strobes are 0, and only reset exits it.
REQ-030 Instruction latency SHALL be 4 cycles for LOAD and 3 cycles for NOOP, STORE, ADD, SUB and illegal opcodes, measured from Fetch entry to the next Fetch entry.
REQ-031 Unreachable encodings 10-15 SHALL transition to Init.

Reset
REQ-032 While ResetN=0, the module SHALL asynchronously force State=Init, PC_Out=0, IR_Out=0 and all strobes and addresses to 0, with NextState reading 1 (Fetch).
REQ-033 A reset mid-instruction, including in Load_A or Store, SHALL abort the instruction and issue no further D_Wr or RF_W_en after ResetN falls.
REQ-034 After ResetN rises, the first Fetch SHALL occur on the second rising edge and load ROM[0].

Verification
REQ-035 Reset, then ROM[0]=0x2A03 (LOAD): the bench SHALL see states 0,1,2,4,5,1; D_Addr=0xA0 in Load_A and Load_B; RF_W_en=1 with RF_W_Addr=3 and RF_s=1 only in Load_B; PC_Out=1.
REQ-036 ROM[1]=0x3124 (ADD): the bench SHALL see, in state 7, Ra=1, Rb=2, Rw=4, ALU_Sel=001 and RF_W_en=1 for 1 cycle; ROM[2]=0x4124 (SUB) SHALL give the same addresses with ALU_Sel=010 in state 8.
REQ-037 ROM[k]=0x1580 (STORE): the bench SHALL see, in state 6, RF_Ra_Addr=5, D_Addr=0x80 and D_Wr=1 for exactly 1 cycle.
REQ-038 Opcode 0x9xxx: the bench SHALL see state 3 and then Fetch, with no strobe asserted.
REQ-039 ROM[0x7F]=0x0000 reached: the PC SHALL wrap to 0; ROM[0]=0x5000 then SHALL hold State=9 indefinitely with IR_Out=0x5000 and the PC frozen.
REQ-040 ResetN dropped mid-cycle during Load_A: State, PC and IR SHALL read 0 immediately without waiting for a clock edge, and no RF_W_en pulse shall occur.
